din_receiver: RTL and testbench

- Receives and decodes the serial Din frame produced by the bot's Din line generator.
- Sits on the sensor-side serial input in the clk_25M domain; recovers the frame's data bits into a parallel word for downstream logic.
- Frame format:
  - line idles low;
  - one start bit high;
  - DATA_W data bits, MSB first;
  - one stop bit low (the return to idle serves as the stop bit).
- Each bit lasts BIT_CYCLES clocks.

---
 rtl/din_receiver.sv | 187 ++++++++++++++++++
 tb/tb_din_receiver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/din_receiver.sv
// din_receiver
// Decodes the serial Din frame: the line idles low, then one start bit high,
// then DATA_W data bits MSB first, then the return to low that acts as the
// stop bit. Every bit lasts BIT_CYCLES clocks. Each bit is sampled near its
// middle, and all decisions use the synchronized input only.
//
// Ports
//   clk_25M    : system clock, rising edge
//   rst        : synchronous active-high reset
//   din        : serial frame input, asynchronous to clk_25M
//   data_out   : last correctly framed word, MSB = first data bit
//   data_valid : one-cycle pulse, data_out was just updated
//   frame_err  : one-cycle pulse, stop bit was sampled high
//   busy       : high whenever the receiver is not idle
//   frame_cnt  : count of good frames, wraps 255 -> 0
module din_receiver #(
    parameter int DATA_W      = 2,
    parameter int BIT_CYCLES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_25M,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int HALF  = (BIT_CYCLES - 1) / 2;
    localparam int BC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BC_W-1:0]  BC_HALF  = BC_W'(HALF);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_LOW
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               din_s;
    logic [BC_W-1:0]    bc;
    logic [IDX_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shift_q;
    logic               bc_mid;
    logic               bc_last;

    // ---- input synchronizer ----
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign din_s   = sync_q[SYNC_STAGES-1];
    assign bc_mid  = (bc == BC_HALF);
    assign bc_last = (bc == BC_LAST);

    // ---- state register ----
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- next-state logic ----
    // The detection cycle is bc=0 of the start bit. When HALF is 0 the start
    // sample coincides with detection and is trivially high, so START only
    // has to check its midpoint for HALF >= 1 (it is always entered at bc=1).
    // With one clock per bit the start bit is over at detection, so the
    // receiver goes straight to DATA.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (din_s) begin
                    state_next = (BIT_CYCLES == 1) ? DATA : START;
                end
            end
            START: begin
                if (bc_mid && !din_s) begin
                    state_next = IDLE;
                end else if (bc_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bc_last && (bit_idx == IDX_LAST)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bc_mid) begin
                    state_next = din_s ? WAIT_LOW : IDLE;
                end
            end
            WAIT_LOW: begin
                if (!din_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- bit timing, shift register and result registers ----
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            bc         <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    bc      <= '0;
                    if (din_s && (BIT_CYCLES > 1)) begin
                        bc <= BC_W'(1);
                    end
                end
                START: begin
                    bit_idx <= '0;
                    bc      <= bc_last ? '0 : bc + BC_W'(1);
                end
                DATA: begin
                    if (bc_mid) begin
                        shift_q[0] <= din_s;
                        for (int i = 1; i < DATA_W; i++) begin
                            shift_q[i] <= shift_q[i-1];
                        end
                    end
                    if (bc_last) begin
                        bc      <= '0;
                        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);
                    end else begin
                        bc <= bc + BC_W'(1);
                    end
                end
                STOP: begin
                    // bc never passes HALF here: the sample ends the state.
                    bc <= bc + BC_W'(1);
                    if (bc_mid) begin
                        if (!din_s) begin
                            data_out   <= shift_q;
                            frame_cnt  <= frame_cnt + 8'd1;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    bc <= '0;
                end
                default: begin
                    bc      <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // ---- outputs ----
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_din_receiver.sv
// Testbench for din_receiver. Two instances: one with default parameters
// (2 data bits, 1 clock per bit) and one with 8 data bits at 4 clocks per
// bit. Frames are driven as line waveforms; the expected word, good-frame
// count and pulse cycle of each frame follow from the frame format and the
// mid-bit sampling rule.
module tb_din_receiver;

    localparam int SYNC = 2;
    localparam int WA   = 2;
    localparam int BCA  = 1;
    localparam int WB   = 8;
    localparam int BCB  = 4;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [7:0]  cnt;
    } ev_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic          rst_a, rst_b, din_a, din_b;
    logic [WA-1:0] data_out_a;
    logic [WB-1:0] data_out_b;
    logic          data_valid_a, data_valid_b;
    logic          frame_err_a, frame_err_b;
    logic          busy_a, busy_b;
    logic [7:0]    frame_cnt_a, frame_cnt_b;

    din_receiver #(.DATA_W(WA), .BIT_CYCLES(BCA), .SYNC_STAGES(SYNC)) dut_a (
        .clk_25M(clk), .rst(rst_a), .din(din_a),
        .data_out(data_out_a), .data_valid(data_valid_a),
        .frame_err(frame_err_a), .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    din_receiver #(.DATA_W(WB), .BIT_CYCLES(BCB), .SYNC_STAGES(SYNC)) dut_b (
        .clk_25M(clk), .rst(rst_b), .din(din_b),
        .data_out(data_out_b), .data_valid(data_valid_b),
        .frame_err(frame_err_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t va_q[$];
    ev_t vb_q[$];
    int  ea_q[$];
    int  eb_q[$];
    int  overlap = 0;

    function automatic ev_t mk(input int c, input logic [15:0] d, input logic [7:0] n);
        ev_t e;
        e.cyc  = c;
        e.data = d;
        e.cnt  = n;
        return e;
    endfunction

    always @(negedge clk) begin
        if (data_valid_a) va_q.push_back(mk(cyc, {14'b0, data_out_a}, frame_cnt_a));
        if (data_valid_b) vb_q.push_back(mk(cyc, {8'b0, data_out_b}, frame_cnt_b));
        if (frame_err_a) ea_q.push_back(cyc);
        if (frame_err_b) eb_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if ((data_valid_a && frame_err_a) || (data_valid_b && frame_err_b))
            overlap <= overlap + 1;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the first driven start-bit clock to the result pulse:
    // synchronizer delay, start + data bits, half a stop bit, one register.
    function automatic int lat(input int w, input int bc);
        return SYNC + bc * (w + 1) + (bc - 1) / 2 + 1;
    endfunction

    function automatic logic [31:0] outs_a();
        return {19'b0, data_out_a, data_valid_a, frame_err_a, busy_a, frame_cnt_a};
    endfunction

    function automatic logic [31:0] outs_b();
        return {13'b0, data_out_b, data_valid_b, frame_err_b, busy_b, frame_cnt_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_level(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) din_a = v; else din_b = v;
            step();
        end
    endtask

    task automatic send_frame(input int which, input logic [15:0] word, input int w,
                              input int bc, input bit stop_high, output int k);
        k = cyc;
        drive_level(which, 1'b1, bc);
        for (int i = w - 1; i >= 0; i--) drive_level(which, word[i], bc);
        drive_level(which, stop_high, bc);
    endtask

    task automatic expect_valid(input int which, input string tag, input int exp_cyc,
                                input logic [15:0] exp_data, input logic [7:0] exp_cnt);
        ev_t e;
        int  n;
        n = (which == 0) ? va_q.size() : vb_q.size();
        check({tag, "_present"}, 32'(n != 0), 32'd1);
        if (n != 0) begin
            if (which == 0) e = va_q.pop_front(); else e = vb_q.pop_front();
            check({tag, "_cycle"}, 32'(e.cyc), 32'(exp_cyc));
            check({tag, "_data"}, {16'b0, e.data}, {16'b0, exp_data});
            check({tag, "_cnt"}, {24'b0, e.cnt}, {24'b0, exp_cnt});
        end
    endtask

    int          k, k2, m;
    int          ks[256];
    logic [15:0] ds[256];
    logic [7:0]  exp_cnt_a, exp_cnt_b;
    logic [15:0] last_b;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; din_a = 1'b0; din_b = 1'b0;
        repeat (3) step();
        check("reset_a", outs_a(), 32'd0);
        check("reset_b", outs_b(), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        exp_cnt_a = 8'd0; exp_cnt_b = 8'd0; last_b = 16'd0;

        // Minimal frame on the default instance: line 1,0,1 then low.
        drive_level(0, 1'b0, 3);
        send_frame(0, 16'h0001, WA, BCA, 1'b0, k);
        drive_level(0, 1'b0, 10);
        exp_cnt_a = exp_cnt_a + 8'd1;
        expect_valid(0, "t1", k + lat(WA, BCA), 16'h0001, exp_cnt_a);
        check("t1_single", 32'(va_q.size()), 32'd0);
        check("t1_no_err", 32'(ea_q.size()), 32'd0);

        // Two back-to-back 8-bit frames.
        drive_level(1, 1'b0, 3);
        send_frame(1, 16'h00A5, WB, BCB, 1'b0, k);
        send_frame(1, 16'h003C, WB, BCB, 1'b0, k2);
        drive_level(1, 1'b0, 50);
        expect_valid(1, "t2a", k + lat(WB, BCB), 16'h00A5, 8'd1);
        expect_valid(1, "t2b", k2 + lat(WB, BCB), 16'h003C, 8'd2);
        exp_cnt_b = 8'd2; last_b = 16'h003C;
        check("t2_count", 32'(vb_q.size()), 32'd0);
        check("t2_no_err", 32'(eb_q.size()), 32'd0);

        // Random words with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            ds[i] = 16'($urandom_range(0, 255));
            send_frame(1, ds[i], WB, BCB, 1'b0, ks[i]);
            drive_level(1, 1'b0, $urandom_range(0, 5));
        end
        drive_level(1, 1'b0, 50);
        for (int i = 0; i < 8; i++) begin
            exp_cnt_b = exp_cnt_b + 8'd1;
            expect_valid(1, $sformatf("rnd%0d", i), ks[i] + lat(WB, BCB), ds[i], exp_cnt_b);
            last_b = ds[i];
        end
        check("rnd_frame_cnt", 32'(frame_cnt_b), 32'(exp_cnt_b));

        // Stop bit high, line stuck high, then released.
        send_frame(1, 16'h005A, WB, BCB, 1'b1, k);
        drive_level(1, 1'b1, 10);
        check("t3_busy_stuck", 32'(busy_b), 32'd1);
        drive_level(1, 1'b1, 10);
        m = cyc;
        din_b = 1'b0;
        step();
        step();
        check("t3_busy_hold", 32'(busy_b), 32'd1);
        step();
        check("t3_busy_drop", 32'(busy_b), 32'd0);
        drive_level(1, 1'b0, 40);
        check("t3_err_count", 32'(eb_q.size()), 32'd1);
        if (eb_q.size() != 0) check("t3_err_cycle", 32'(eb_q[0]), 32'(k + lat(WB, BCB)));
        check("t3_no_valid", 32'(vb_q.size()), 32'd0);
        check("t3_data_kept", {24'b0, data_out_b}, {16'b0, last_b});
        check("t3_cnt_kept", 32'(frame_cnt_b), 32'(exp_cnt_b));
        eb_q.delete();

        // One-clock glitch.
        k = cyc;
        din_b = 1'b1;
        step();
        din_b = 1'b0;
        step();
        check("t4_idle_at_d", 32'(busy_b), 32'd0);
        step();
        check("t4_busy_start", 32'(busy_b), 32'd1);
        step();
        check("t4_busy_drop", 32'(busy_b), 32'd0);
        drive_level(1, 1'b0, 50);
        check("t4_no_valid", 32'(vb_q.size()), 32'd0);
        check("t4_no_err", 32'(eb_q.size()), 32'd0);
        check("t4_cnt_kept", 32'(frame_cnt_b), 32'(exp_cnt_b));

        // Reset during data bit 3 (as seen by the receiver after the synchronizer).
        k = cyc;
        drive_level(1, 1'b1, BCB);
        drive_level(1, 1'b1, BCB);
        drive_level(1, 1'b0, BCB);
        drive_level(1, 1'b1, BCB);
        drive_level(1, 1'b1, 2);
        din_b = 1'b1;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        din_b = 1'b0;
        check("t5_cycle", 32'(cyc), 32'(k + 19));
        check("t5_outs_zero", outs_b(), 32'd0);
        exp_cnt_b = 8'd0;
        drive_level(1, 1'b0, 50);
        check("t5_no_valid", 32'(vb_q.size()), 32'd0);
        check("t5_no_err", 32'(eb_q.size()), 32'd0);
        send_frame(1, 16'h00C3, WB, BCB, 1'b0, k);
        drive_level(1, 1'b0, 50);
        exp_cnt_b = exp_cnt_b + 8'd1;
        expect_valid(1, "t5_clean", k + lat(WB, BCB), 16'h00C3, exp_cnt_b);

        // 256 back-to-back frames from a fresh count.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("t6_reset", outs_a(), 32'd0);
        exp_cnt_a = 8'd0;
        va_q.delete();
        for (int i = 0; i < 256; i++) begin
            ds[i] = 16'($urandom_range(0, 3));
            send_frame(0, ds[i], WA, BCA, 1'b0, ks[i]);
        end
        drive_level(0, 1'b0, 20);
        check("t6_count", 32'(va_q.size()), 32'd256);
        for (int i = 0; i < 256; i++) begin
            exp_cnt_a = exp_cnt_a + 8'd1;
            expect_valid(0, $sformatf("t6_%0d", i), ks[i] + lat(WA, BCA), ds[i], exp_cnt_a);
        end
        check("t6_wrap", 32'(frame_cnt_a), 32'd0);
        check("a_no_err", 32'(ea_q.size()), 32'd0);
        check("no_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
